// File: rtl/hazard_pkg.sv
// Shared scoreboard types and helpers for the hazard/forwarding unit.
// Destination indices are zero-extended to SB_DST_W inside entries.
package hazard_pkg;

  localparam int SB_DST_W = 8;
  localparam logic [SB_DST_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                valid;
    logic [SB_DST_W-1:0] dst;
    logic                wen;
    logic                is_load;
  } sb_entry_t;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic is_writer(input sb_entry_t e);
    return e.valid && e.wen && (e.dst != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// Decode/EX/stage-data bundle between the pipeline and the
// hazard/forwarding unit.
interface hazard_fwd_unit_if #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NSTAGES = 3,
  parameter int NSRC    = 2,
  parameter int CNT_W   = 16
);
  logic                      id_valid;
  logic [NSRC*REG_AW-1:0]    id_src_sel;
  logic [NSRC-1:0]           id_src_used;
  logic [REG_AW-1:0]         id_dst;
  logic                      id_wen;
  logic                      id_is_load;
  logic                      ex_redirect;
  logic                      mem_busy;
  logic [NSTAGES*DATA_W-1:0] stage_data;
  logic [NSTAGES-1:0]        stage_data_ok;
  logic                      stall_id;
  logic                      flush_if;
  logic                      flush_id;
  logic                      freeze;
  logic [NSRC-1:0]           fwd_hit;
  logic [NSRC*DATA_W-1:0]    fwd_data;
  logic [CNT_W-1:0]          stall_cnt;
  logic [CNT_W-1:0]          flush_cnt;

  modport master (
    output id_valid, id_src_sel, id_src_used,
    output id_dst, id_wen, id_is_load,
    output ex_redirect, mem_busy,
    output stage_data, stage_data_ok,
    input  stall_id, flush_if, flush_id, freeze,
    input  fwd_hit, fwd_data, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_src_sel, id_src_used,
    input  id_dst, id_wen, id_is_load,
    input  ex_redirect, mem_busy,
    input  stage_data, stage_data_ok,
    output stall_id, flush_if, flush_id, freeze,
    output fwd_hit, fwd_data, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_fwd_unit_fwd_match.sv
// Priority match of one EX source against the older scoreboard
// entries (MEM and beyond); the youngest ready writer wins.
module fwd_match
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int NOLD   = 2,
  parameter int IDX_W  = 2
) (
  input  sb_entry_t         ent [NOLD],
  input  logic [NOLD-1:0]   ok,
  input  logic [REG_AW-1:0] sel,
  input  logic              used,
  output logic              hit,
  output logic [IDX_W-1:0]  idx
);

  logic [SB_DST_W-1:0] key;

  assign key = SB_DST_W'(sel);

  // Walk oldest to youngest so the youngest match is written last.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = NOLD - 1; k >= 0; k--) begin
      if (used && key != REG_ZERO &&
          is_writer(ent[k]) &&
          ent[k].dst == key && ok[k]) begin
        hit = 1'b1;
        idx = IDX_W'(k + 1);
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Scoreboard-based hazard and forwarding unit: EX operand forwarding,
// load-use stall, redirect flush, memory-wait freeze, perf counters.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int NSTAGES    = 3,
  parameter int NSRC       = 2,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_W      = 16
) (
  input logic              CLK,
  input logic              RST,
  hazard_fwd_unit_if.slave bus
);

  localparam int IDX_W = idx_w(NSTAGES);
  localparam int NOLD  = NSTAGES - 1;

  sb_entry_t sb_q   [NSTAGES];
  sb_entry_t sb_d   [NSTAGES];
  sb_entry_t sb_old [NOLD];
  sb_entry_t id_ent;

  logic [NSRC*REG_AW-1:0] ex_sel_q, ex_sel_d;
  logic [NSRC-1:0]        ex_used_q, ex_used_d;
  logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]       flush_cnt_q, flush_cnt_d;

  logic [SB_DST_W-1:0] id_key [NSRC];
  logic                load_use;
  logic                redirect;
  logic                stall;
  logic                push;
  logic [NSRC-1:0]     hit;
  logic [IDX_W-1:0]    idx [NSRC];
  logic                unused_stage0;

  // The EX entry never has a result to forward.
  assign unused_stage0 = ^{bus.stage_data[DATA_W-1:0],
                           bus.stage_data_ok[0]};

  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      id_key[i] = SB_DST_W'(bus.id_src_sel[i*REG_AW +: REG_AW]);
    end
  end

  always_comb begin
    load_use = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      for (int k = 0; k < NSTAGES; k++) begin
        if (k + 1 < LOAD_STAGE &&
            bus.id_src_used[i] &&
            id_key[i] != REG_ZERO &&
            is_writer(sb_q[k]) &&
            sb_q[k].is_load &&
            sb_q[k].dst == id_key[i]) begin
          load_use = 1'b1;
        end
      end
    end
  end

  assign redirect = bus.ex_redirect && !bus.mem_busy;
  assign stall    = bus.id_valid && load_use &&
                    !bus.mem_busy && !bus.ex_redirect;
  assign push     = bus.id_valid && !stall && !bus.ex_redirect;

  assign bus.freeze    = bus.mem_busy;
  assign bus.flush_if  = redirect;
  assign bus.flush_id  = redirect;
  assign bus.stall_id  = stall;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

  assign id_ent = {1'b1, SB_DST_W'(bus.id_dst),
                   bus.id_wen, bus.id_is_load};

  always_comb begin
    sb_d        = sb_q;
    ex_sel_d    = ex_sel_q;
    ex_used_d   = ex_used_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!bus.mem_busy) begin
      sb_d[0] = push ? id_ent : '0;
      for (int k = 1; k < NSTAGES; k++) begin
        sb_d[k] = sb_q[k-1];
      end
      ex_sel_d  = push ? bus.id_src_sel : '0;
      ex_used_d = push ? bus.id_src_used : '0;
      if (stall && !(&stall_cnt_q)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (redirect && !(&flush_cnt_q)) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < NSTAGES; k++) begin
        sb_q[k] <= '0;
      end
      ex_sel_q    <= '0;
      ex_used_q   <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      sb_q        <= sb_d;
      ex_sel_q    <= ex_sel_d;
      ex_used_q   <= ex_used_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    for (int k = 0; k < NOLD; k++) begin
      sb_old[k] = sb_q[k+1];
    end
  end

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    fwd_match #(
      .REG_AW (REG_AW),
      .NOLD   (NOLD),
      .IDX_W  (IDX_W)
    ) u_match (
      .ent  (sb_old),
      .ok   (bus.stage_data_ok[NSTAGES-1:1]),
      .sel  (ex_sel_q[i*REG_AW +: REG_AW]),
      .used (ex_used_q[i]),
      .hit  (hit[i]),
      .idx  (idx[i])
    );

    assign bus.fwd_data[i*DATA_W +: DATA_W] =
      hit[i] ? bus.stage_data[int'(idx[i])*DATA_W +: DATA_W]
             : '0;
  end

  assign bus.fwd_hit = hit;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: reset, forwarding, load-use,
// priority, redirect, freeze and counter saturation.
module tb_hazard_fwd_unit;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NS  = 3;
  localparam int NSR = 2;
  localparam int LS  = 2;
  localparam int CW  = 16;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   failures = 0;

  hazard_fwd_unit_if #(
    .DATA_W(DW), .REG_AW(AW), .NSTAGES(NS),
    .NSRC(NSR), .CNT_W(CW)
  ) hif ();

  hazard_fwd_unit #(
    .DATA_W(DW), .REG_AW(AW), .NSTAGES(NS),
    .NSRC(NSR), .LOAD_STAGE(LS), .CNT_W(CW)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (hif)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    hif.id_valid    = 1'b0;
    hif.id_src_sel  = '0;
    hif.id_src_used = '0;
    hif.id_dst      = '0;
    hif.id_wen      = 1'b0;
    hif.id_is_load  = 1'b0;
    hif.ex_redirect = 1'b0;
    hif.mem_busy    = 1'b0;
  endtask

  task automatic drive(input logic [AW-1:0] d,
                       input logic [AW-1:0] s1,
                       input logic [AW-1:0] s0,
                       input logic [1:0] used,
                       input logic wen,
                       input logic ld);
    hif.id_valid    = 1'b1;
    hif.id_dst      = d;
    hif.id_src_sel  = {s1, s0};
    hif.id_src_used = used;
    hif.id_wen      = wen;
    hif.id_is_load  = ld;
  endtask

  task automatic set_data(input logic [DW-1:0] d2,
                          input logic [DW-1:0] d1,
                          input logic [DW-1:0] d0,
                          input logic [2:0] ok);
    hif.stage_data    = {d2, d1, d0};
    hif.stage_data_ok = ok;
  endtask

  task automatic drain();
    idle();
    repeat (NS) tick();
  endtask

  task automatic test_reset();
    idle();
    set_data('0, '0, '0, 3'b000);
    RST = 1'b1;
    repeat (2) tick();
    RST = 1'b0;
    tick();
    checks++;
    if (hif.stall_cnt !== 16'h0 || hif.flush_cnt !== 16'h0) begin
      failures++;
      $display("FAIL rst_cnt got=%0h/%0h exp=0/0",
               hif.stall_cnt, hif.flush_cnt);
    end
    checks++;
    if (hif.fwd_hit !== 2'b00 || hif.freeze !== 1'b0) begin
      failures++;
      $display("FAIL rst_out got hit=%0b frz=%0b exp=0/0",
               hif.fwd_hit, hif.freeze);
    end
    drive(5'd5, 5'd0, 5'd2, 2'b01, 1'b1, 1'b1);
    tick();
    drive(5'd6, 5'd5, 5'd5, 2'b11, 1'b1, 1'b0);
    #1;
    checks++;
    if (hif.stall_id !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre_stall got=%0b exp=1", hif.stall_id);
    end
    tick();
    checks++;
    if (hif.stall_cnt !== 16'd1) begin
      failures++;
      $display("FAIL rst_pre_cnt got=%0h exp=1", hif.stall_cnt);
    end
    RST = 1'b1;
    #1;
    checks++;
    if (hif.stall_id !== 1'b0 || hif.flush_if !== 1'b0 ||
        hif.flush_id !== 1'b0 || hif.freeze !== 1'b0) begin
      failures++;
      $display("FAIL rst_async_ctl got=%0b%0b%0b%0b exp=0000",
               hif.stall_id, hif.flush_if, hif.flush_id, hif.freeze);
    end
    checks++;
    if (hif.fwd_hit !== 2'b00 || hif.fwd_data !== 64'h0 ||
        hif.stall_cnt !== 16'h0 || hif.flush_cnt !== 16'h0) begin
      failures++;
      $display("FAIL rst_async_dat got hit=%0b data=%0h sc=%0h fc=%0h exp=0",
               hif.fwd_hit, hif.fwd_data, hif.stall_cnt, hif.flush_cnt);
    end
    tick();
    RST = 1'b0;
    idle();
    tick();
  endtask

  task automatic test_fwd_basic();
    drain();
    set_data(32'h77, 32'h15, 32'h99, 3'b111);
    drive(5'd3, 5'd2, 5'd1, 2'b11, 1'b1, 1'b0);
    tick();
    drive(5'd4, 5'd3, 5'd3, 2'b11, 1'b1, 1'b0);
    #1;
    checks++;
    if (hif.stall_id !== 1'b0) begin
      failures++;
      $display("FAIL alu_nostall got=%0b exp=0", hif.stall_id);
    end
    tick();
    idle();
    #1;
    checks++;
    if (hif.fwd_hit !== 2'b11) begin
      failures++;
      $display("FAIL fwd_hit got=%0b exp=11", hif.fwd_hit);
    end
    checks++;
    if (hif.fwd_data !== {32'h15, 32'h15}) begin
      failures++;
      $display("FAIL fwd_data got=%0h exp=%0h",
               hif.fwd_data, {32'h15, 32'h15});
    end
  endtask

  task automatic test_load_use();
    drain();
    set_data(32'hDEAD, 32'h1111, 32'h0, 3'b110);
    drive(5'd5, 5'd0, 5'd2, 2'b01, 1'b1, 1'b1);
    tick();
    drive(5'd6, 5'd1, 5'd5, 2'b11, 1'b1, 1'b0);
    #1;
    checks++;
    if (hif.stall_id !== 1'b1) begin
      failures++;
      $display("FAIL lu_stall got=%0b exp=1", hif.stall_id);
    end
    tick();
    checks++;
    if (hif.stall_id !== 1'b0) begin
      failures++;
      $display("FAIL lu_one_cycle got=%0b exp=0", hif.stall_id);
    end
    checks++;
    if (hif.stall_cnt !== 16'd1 || hif.fwd_hit !== 2'b00) begin
      failures++;
      $display("FAIL lu_bubble got cnt=%0h hit=%0b exp=1/00",
               hif.stall_cnt, hif.fwd_hit);
    end
    tick();
    idle();
    #1;
    checks++;
    if (hif.fwd_hit !== 2'b01) begin
      failures++;
      $display("FAIL lu_fwd_hit got=%0b exp=01", hif.fwd_hit);
    end
    checks++;
    if (hif.fwd_data[31:0] !== 32'hDEAD) begin
      failures++;
      $display("FAIL lu_fwd_data got=%0h exp=dead", hif.fwd_data[31:0]);
    end
    checks++;
    if (hif.stall_cnt !== 16'd1) begin
      failures++;
      $display("FAIL lu_cnt got=%0h exp=1", hif.stall_cnt);
    end
  endtask

  task automatic test_priority();
    drain();
    set_data(32'hB, 32'hA, 32'h5, 3'b111);
    drive(5'd7, 5'd1, 5'd1, 2'b00, 1'b1, 1'b0);
    tick();
    drive(5'd7, 5'd2, 5'd2, 2'b00, 1'b1, 1'b0);
    tick();
    drive(5'd8, 5'd0, 5'd7, 2'b11, 1'b1, 1'b0);
    tick();
    idle();
    #1;
    checks++;
    if (hif.fwd_hit !== 2'b01 || hif.fwd_data[31:0] !== 32'hA) begin
      failures++;
      $display("FAIL waw_young got hit=%0b data=%0h exp=01/a",
               hif.fwd_hit, hif.fwd_data[31:0]);
    end
    hif.stage_data_ok = 3'b101;
    #1;
    checks++;
    if (hif.fwd_hit !== 2'b01 || hif.fwd_data[31:0] !== 32'hB) begin
      failures++;
      $display("FAIL waw_notok got hit=%0b data=%0h exp=01/b",
               hif.fwd_hit, hif.fwd_data[31:0]);
    end
    hif.stage_data_ok = 3'b001;
    #1;
    checks++;
    if (hif.fwd_hit !== 2'b00) begin
      failures++;
      $display("FAIL waw_none got=%0b exp=00", hif.fwd_hit);
    end
    drain();
    hif.stage_data_ok = 3'b111;
    drive(5'd0, 5'd1, 5'd1, 2'b00, 1'b1, 1'b0);
    tick();
    drive(5'd9, 5'd0, 5'd0, 2'b11, 1'b1, 1'b0);
    tick();
    idle();
    #1;
    checks++;
    if (hif.fwd_hit !== 2'b00) begin
      failures++;
      $display("FAIL r0_fwd got=%0b exp=00", hif.fwd_hit);
    end
    drive(5'd0, 5'd1, 5'd1, 2'b00, 1'b1, 1'b1);
    tick();
    drive(5'd9, 5'd0, 5'd0, 2'b11, 1'b1, 1'b0);
    #1;
    checks++;
    if (hif.stall_id !== 1'b0) begin
      failures++;
      $display("FAIL r0_stall got=%0b exp=0", hif.stall_id);
    end
  endtask

  task automatic test_redirect();
    drain();
    set_data(32'h0, 32'h44, 32'h0, 3'b111);
    drive(5'd5, 5'd0, 5'd2, 2'b01, 1'b1, 1'b1);
    tick();
    drive(5'd6, 5'd1, 5'd5, 2'b01, 1'b1, 1'b0);
    hif.ex_redirect = 1'b1;
    #1;
    checks++;
    if (hif.flush_if !== 1'b1 || hif.flush_id !== 1'b1 ||
        hif.stall_id !== 1'b0) begin
      failures++;
      $display("FAIL rd_beats_stall got=%0b%0b%0b exp=110",
               hif.flush_if, hif.flush_id, hif.stall_id);
    end
    tick();
    idle();
    #1;
    checks++;
    if (hif.flush_cnt !== 16'd1 || hif.stall_cnt !== 16'd1) begin
      failures++;
      $display("FAIL rd_cnt got fc=%0h sc=%0h exp=1/1",
               hif.flush_cnt, hif.stall_cnt);
    end
    checks++;
    if (hif.fwd_hit !== 2'b00 || hif.flush_if !== 1'b0) begin
      failures++;
      $display("FAIL rd_bubble got hit=%0b fif=%0b exp=00/0",
               hif.fwd_hit, hif.flush_if);
    end
  endtask

  task automatic test_freeze();
    drain();
    set_data(32'hB, 32'hA, 32'h0, 3'b111);
    drive(5'd7, 5'd1, 5'd1, 2'b00, 1'b1, 1'b0);
    tick();
    drive(5'd9, 5'd1, 5'd7, 2'b01, 1'b1, 1'b0);
    tick();
    idle();
    hif.ex_redirect = 1'b1;
    hif.mem_busy    = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (hif.freeze !== 1'b1 || hif.flush_if !== 1'b0 ||
          hif.flush_id !== 1'b0 || hif.stall_id !== 1'b0) begin
        failures++;
        $display("FAIL frz_ctl c=%0d got=%0b%0b%0b%0b exp=1000", c,
                 hif.freeze, hif.flush_if, hif.flush_id, hif.stall_id);
      end
      checks++;
      if (hif.fwd_hit !== 2'b01 || hif.fwd_data[31:0] !== 32'hA) begin
        failures++;
        $display("FAIL frz_hold c=%0d got hit=%0b data=%0h exp=01/a",
                 c, hif.fwd_hit, hif.fwd_data[31:0]);
      end
      tick();
    end
    hif.mem_busy = 1'b0;
    #1;
    checks++;
    if (hif.flush_if !== 1'b1 || hif.flush_id !== 1'b1 ||
        hif.freeze !== 1'b0 || hif.flush_cnt !== 16'd1) begin
      failures++;
      $display("FAIL frz_release got=%0b%0b%0b fc=%0h exp=110/1",
               hif.flush_if, hif.flush_id, hif.freeze, hif.flush_cnt);
    end
    tick();
    hif.ex_redirect = 1'b0;
    #1;
    checks++;
    if (hif.flush_cnt !== 16'd2 || hif.fwd_hit !== 2'b00) begin
      failures++;
      $display("FAIL frz_after got fc=%0h hit=%0b exp=2/00",
               hif.flush_cnt, hif.fwd_hit);
    end
  endtask

  task automatic test_saturate();
    idle();
    hif.ex_redirect = 1'b1;
    repeat (65531) tick();
    checks++;
    if (hif.flush_cnt !== 16'hFFFD) begin
      failures++;
      $display("FAIL sat_pre got=%0h exp=fffd", hif.flush_cnt);
    end
    tick();
    checks++;
    if (hif.flush_cnt !== 16'hFFFE) begin
      failures++;
      $display("FAIL sat_fffe got=%0h exp=fffe", hif.flush_cnt);
    end
    tick();
    checks++;
    if (hif.flush_cnt !== 16'hFFFF) begin
      failures++;
      $display("FAIL sat_ffff got=%0h exp=ffff", hif.flush_cnt);
    end
    repeat (3) tick();
    checks++;
    if (hif.flush_cnt !== 16'hFFFF || hif.stall_cnt !== 16'd1) begin
      failures++;
      $display("FAIL sat_hold got fc=%0h sc=%0h exp=ffff/1",
               hif.flush_cnt, hif.stall_cnt);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_fwd_basic();
    test_load_use();
    test_priority();
    test_redirect();
    test_freeze();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
